display_mode_ctrl: RTL
======================

DISPLAY_MODE_CTRL -- requirements
Module: display_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive cycles a synchronized button level must differ from its debounced level before being accepted (10 ms at 100 MHz); legal range 1..2^24-1.
REQ-002 Parameter IDLE_TIMEOUT_CYCLES, default 32'd3000000000: cycles without an accepted press before auto-blank (30 s at 100 MHz); legal range 1..2^32-1.
REQ-003 clk  input  1  single system clock; all state rising-edge clocked.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_next  input  1  raw, asynchronous pushbutton, high = pressed; advances display mode.
REQ-006 btn_blank  input  1  raw, asynchronous pushbutton, high = pressed; toggles blank.
REQ-007 timeout_en  input  1  synchronous; 1 enables idle auto-blank.
REQ-008 mode  output  2  registered display-mode select driving the segment/anode mux; 0,1,2 = data views, 3 = blank.
REQ-009 blanked  output  1  registered; 1 exactly when mode == 3.
REQ-010 mode_changed  output  1  registered one-cycle pulse on every cycle in which mode takes a new value.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Per button, a debounced level register and a 24-bit counter SHALL exist; the counter SHALL clear on any cycle where synchronized level equals the debounced level, else increment.
REQ-013 The debounced level SHALL take the synchronized value on the DEBOUNCE_CYCLES-th consecutive differing cycle, and that button's counter SHALL clear on the same edge.
REQ-014 A press event SHALL be a one-cycle pulse on the debounced level's 0->1 transition; releases SHALL generate no event; holding a button SHALL generate exactly one event.
REQ-015 Latency: raw button held high from clock edge N SHALL make the debounced level high after edge N+2+DEBOUNCE_CYCLES-1 and mode update on the following edge; bouncing shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-016 The mode FSM SHALL have states SHOW (mode in 0..2) and BLANK (mode = 3), plus a 2-bit last_mode register holding the view to restore.
REQ-017 SHOW, next event: mode SHALL advance 0->1->2->0 (2 wraps to 0).
REQ-018 SHOW, blank event: last_mode <= mode, mode <= 3.
REQ-019 BLANK, next or blank event: mode <= last_mode (no advance).
REQ-020 Simultaneous next and blank events SHALL be treated as a blank event only.
REQ-021 A 32-bit idle counter SHALL clear on any press event, clear while in BLANK, clear while timeout_en = 0, otherwise increment, saturating at IDLE_TIMEOUT_CYCLES-1.
REQ-022 In SHOW with timeout_en = 1 and idle counter == IDLE_TIMEOUT_CYCLES-1, the FSM SHALL perform the blank-event action of REQ-018 on that edge.
REQ-023 A press event in the same cycle as a timeout SHALL take priority; timeout is suppressed and the counter clears.
REQ-024 Deasserting timeout_en SHALL never change mode by itself.
REQ-025 mode_changed SHALL assert on the edge where mode is loaded with a value different from its current value, and SHALL be 0 otherwise; it rises together with the new mode value.
REQ-026 mode SHALL never hold a value other than as given by REQ-017..REQ-022.

Reset
REQ-027 On reset assertion, asynchronously: mode = 0, last_mode = 0, blanked = 0, mode_changed = 0, all synchronizer flops, debounced levels, debounce counters and idle counter = 0.
REQ-028 A button held high through reset release SHALL be accepted as one press once debounced after release.
REQ-029 Reset mid-debounce or mid-timeout SHALL discard the partial count; no event may be produced from pre-reset samples.

Verification (DEBOUNCE_CYCLES = 4, IDLE_TIMEOUT_CYCLES = 20)
REQ-030 Reset, btn_next high from edge 10 -> mode 0->1 after edge 16, mode_changed high exactly one cycle; holding 100 cycles -> no further change.
REQ-031 btn_next toggling every 2 cycles for 40 cycles -> mode stays 0, mode_changed never asserts.
REQ-032 Four clean btn_next presses (8 high, 8 low) -> mode 1,2,0,1.
REQ-033 In mode 2, btn_blank press -> mode 3, blanked 1; btn_next press -> mode 2, blanked 0.
REQ-034 timeout_en = 1, mode 1, no presses -> mode 3 after 20 cycles; press landing on the timeout cycle -> mode advances to 2, no blank.
REQ-035 btn_next and btn_blank pressed same cycle in mode 0 -> mode 3; reset asserted mid-debounce -> all outputs 0 immediately, no mode change after release.

Source files
------------

// File: rtl/display_mode_ctrl.sv
// Display-mode selector: two debounced pushbuttons step through three data views
// and a blank view, with an optional idle auto-blank that restores the last view.
module display_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter logic [31:0] IDLE_TIMEOUT_CYCLES = 32'd3000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_blank,
    input  logic       timeout_en,
    output logic [1:0] mode,
    output logic       blanked,
    output logic       mode_changed
);

    localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] IDLE_LAST = IDLE_TIMEOUT_CYCLES - 32'd1;
    localparam logic [1:0]  MODE_BLANK = 2'd3;

    typedef enum logic {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t      state;
    logic [1:0]  last_mode;
    logic [1:0]  raw;
    logic [1:0]  sync_p0;
    logic [1:0]  sync_p1;
    logic [1:0]  db_level;
    logic [1:0]  press;
    logic [31:0] idle_cnt;
    logic        next_evt;
    logic        blank_evt;
    logic        any_evt;
    logic        timeout_hit;

    function automatic logic [31:0] idle_sat_inc(input logic [31:0] value);
        return (value >= IDLE_LAST) ? IDLE_LAST : value + 32'd1;
    endfunction

    function automatic logic [1:0] next_view(input logic [1:0] view);
        return (view >= 2'd2) ? 2'd0 : view + 2'd1;
    endfunction

    assign raw = {btn_blank, btn_next};

    // Stage boundary: two-flop synchronizer on the raw buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Stage boundary: per-button debounce; press pulses on the accepted rising level
    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic [23:0] db_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                db_cnt      <= '0;
                db_level[g] <= 1'b0;
                press[g]    <= 1'b0;
            end else begin
                press[g] <= 1'b0;
                if (sync_p1[g] == db_level[g]) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt      <= '0;
                    db_level[g] <= sync_p1[g];
                    press[g]    <= sync_p1[g];
                end else begin
                    db_cnt <= db_cnt + 24'd1;
                end
            end
        end
    end

    assign next_evt    = press[0];
    assign blank_evt   = press[1];
    assign any_evt     = next_evt | blank_evt;
    assign timeout_hit = (state == SHOW) && timeout_en && (idle_cnt == IDLE_LAST) && !any_evt;

    // Stage boundary: idle counter, held at zero whenever blanking cannot apply
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (any_evt || (state == BLANK) || !timeout_en) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_sat_inc(idle_cnt);
        end
    end

    // Stage boundary: mode FSM; a blank press outranks next, and any press outranks timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= SHOW;
            mode         <= 2'd0;
            last_mode    <= 2'd0;
            blanked      <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            case (state)
                SHOW: begin
                    if (blank_evt || timeout_hit) begin
                        last_mode    <= mode;
                        mode         <= MODE_BLANK;
                        blanked      <= 1'b1;
                        state        <= BLANK;
                        mode_changed <= 1'b1;
                    end else if (next_evt) begin
                        mode         <= next_view(mode);
                        mode_changed <= 1'b1;
                    end
                end
                BLANK: begin
                    if (any_evt) begin
                        mode         <= last_mode;
                        blanked      <= 1'b0;
                        state        <= SHOW;
                        mode_changed <= (last_mode != mode);
                    end
                end
                default: begin
                    state   <= SHOW;
                    mode    <= 2'd0;
                    blanked <= 1'b0;
                end
            endcase
        end
    end

endmodule
